// File: rtl/exec_stage_hs_if.sv
// Handshake bundle for exec_stage_hs: upstream issue port, external FPU port and downstream result port.
// The stage connects through the slave modport; the environment uses the master modport.
interface exec_stage_hs_if #(
    parameter int DATA_W         = 32,
    parameter int INST_MEM_WIDTH = 14,
    parameter int TAG_W          = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_is_fp;
    logic                      in_is_mem;
    logic [3:0]                in_alu_op;
    logic [1:0]                in_src_sel;
    logic [1:0]                in_dst_sel;
    logic                      in_reg_write;
    logic [DATA_W-1:0]         in_op1;
    logic [DATA_W-1:0]         in_op2;
    logic [4:0]                in_rt;
    logic [4:0]                in_rd;
    logic [4:0]                in_sa;
    logic [15:0]               in_imm;
    logic [INST_MEM_WIDTH-1:0] in_pc;
    logic [TAG_W-1:0]          in_tag;

    logic                      fpu_req;
    logic                      fpu_ack;
    logic [3:0]                fpu_op;
    logic [DATA_W-1:0]         fpu_a;
    logic [DATA_W-1:0]         fpu_b;
    logic                      fpu_abort;
    logic                      fpu_done;
    logic [DATA_W-1:0]         fpu_result;
    logic                      fpu_res_ready;

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_result;
    logic [DATA_W-1:0]         out_store_data;
    logic [4:0]                out_rdist;
    logic                      out_reg_write;
    logic                      out_fp;
    logic [INST_MEM_WIDTH-1:0] out_pc;
    logic [INST_MEM_WIDTH-1:0] out_branch_target;
    logic [TAG_W-1:0]          out_tag;

    modport slave (
        input  in_valid, in_is_fp, in_is_mem, in_alu_op, in_src_sel, in_dst_sel,
               in_reg_write, in_op1, in_op2, in_rt, in_rd, in_sa, in_imm, in_pc, in_tag,
        output in_ready,
        output fpu_req, fpu_op, fpu_a, fpu_b, fpu_abort, fpu_res_ready,
        input  fpu_ack, fpu_done, fpu_result,
        output out_valid, out_result, out_store_data, out_rdist, out_reg_write,
               out_fp, out_pc, out_branch_target, out_tag,
        input  out_ready
    );

    modport master (
        output in_valid, in_is_fp, in_is_mem, in_alu_op, in_src_sel, in_dst_sel,
               in_reg_write, in_op1, in_op2, in_rt, in_rd, in_sa, in_imm, in_pc, in_tag,
        input  in_ready,
        input  fpu_req, fpu_op, fpu_a, fpu_b, fpu_abort, fpu_res_ready,
        output fpu_ack, fpu_done, fpu_result,
        input  out_valid, out_result, out_store_data, out_rdist, out_reg_write,
               out_fp, out_pc, out_branch_target, out_tag,
        output out_ready
    );
endinterface

// File: rtl/exec_stage_hs.sv
// Execute stage: single-cycle integer ALU / branch-target path and an in-order
// multi-cycle FP path through an external FPU, with valid/ready on both sides and flush.
module exec_stage_hs #(
    parameter int DATA_W         = 32,
    parameter int INST_MEM_WIDTH = 14,
    parameter int TAG_W          = 8
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  flush,
    exec_stage_hs_if.slave        bus,
    output logic [31:0]           fp_stall_cnt
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FP_ISSUE = 2'd1,
        FP_WAIT  = 2'd2
    } state_t;

    localparam logic [INST_MEM_WIDTH-1:0] PC_ONE = INST_MEM_WIDTH'(1);

    state_t state, state_next;

    logic in_ready;
    logic fpu_req;
    logic fpu_res_ready;
    logic accept;
    logic fp_path;
    logic fp_take;

    logic [DATA_W-1:0]         imm_sext;
    logic [DATA_W-1:0]         op2_sel;
    logic [4:0]                sh;
    logic [DATA_W-1:0]         alu_res;
    logic [4:0]                rdist;
    logic [INST_MEM_WIDTH-1:0] btarget;

    logic                      out_valid_q;
    logic [DATA_W-1:0]         out_result_q;
    logic [DATA_W-1:0]         out_store_q;
    logic [4:0]                out_rdist_q;
    logic                      out_rw_q;
    logic                      out_fp_q;
    logic [INST_MEM_WIDTH-1:0] out_pc_q;
    logic [INST_MEM_WIDTH-1:0] out_bt_q;
    logic [TAG_W-1:0]          out_tag_q;

    logic [3:0]                fp_op_q;
    logic [DATA_W-1:0]         fp_a_q;
    logic [DATA_W-1:0]         fp_b_q;
    logic [DATA_W-1:0]         h_store_q;
    logic [4:0]                h_rdist_q;
    logic                      h_rw_q;
    logic [INST_MEM_WIDTH-1:0] h_pc_q;
    logic [INST_MEM_WIDTH-1:0] h_bt_q;
    logic [TAG_W-1:0]          h_tag_q;
    logic                      abort_q;

    // Operand select, destination select and branch target
    always_comb begin
        imm_sext = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
        op2_sel  = bus.in_op2;
        unique case (bus.in_src_sel)
            2'd0: op2_sel = bus.in_op2;
            2'd1: op2_sel = {{(DATA_W-5){1'b0}}, bus.in_sa};
            2'd2: op2_sel = imm_sext;
            2'd3: op2_sel = {{(DATA_W-16){1'b0}}, bus.in_imm};
            default: op2_sel = bus.in_op2;
        endcase

        rdist = bus.in_rd;
        unique case (bus.in_dst_sel)
            2'd0: rdist = bus.in_rd;
            2'd1: rdist = bus.in_rt;
            2'd2: rdist = 5'd31;
            2'd3: rdist = 5'd0;
            default: rdist = bus.in_rd;
        endcase

        btarget = bus.in_pc + PC_ONE + imm_sext[INST_MEM_WIDTH-1:0];
    end

    always_comb begin
        sh      = op2_sel[4:0];
        alu_res = '0;
        unique case (bus.in_alu_op)
            4'd0:  alu_res = bus.in_op1 + op2_sel;
            4'd1:  alu_res = bus.in_op1 - op2_sel;
            4'd2:  alu_res = bus.in_op1 & op2_sel;
            4'd3:  alu_res = bus.in_op1 | op2_sel;
            4'd4:  alu_res = bus.in_op1 ^ op2_sel;
            4'd5:  alu_res = ~(bus.in_op1 | op2_sel);
            4'd6:  alu_res = bus.in_op1 << sh;
            4'd7:  alu_res = bus.in_op1 >> sh;
            4'd8:  alu_res = $unsigned($signed(bus.in_op1) >>> sh);
            4'd9:  alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.in_op1) < $signed(op2_sel)};
            4'd10: alu_res = {{(DATA_W-1){1'b0}}, bus.in_op1 < op2_sel};
            4'd11: alu_res = op2_sel << 16;
            default: alu_res = '0;
        endcase
    end

    assign fp_path = bus.in_is_fp && !bus.in_is_mem;
    assign accept  = bus.in_valid && in_ready;
    assign fp_take = (state == FP_WAIT) && bus.fpu_done && fpu_res_ready && !flush;

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        fpu_req       = 1'b0;
        fpu_res_ready = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = (!out_valid_q || bus.out_ready) && !flush && !reset;
                if (bus.in_valid && in_ready && fp_path) state_next = FP_ISSUE;
            end
            FP_ISSUE: begin
                fpu_req = 1'b1;
                if (bus.fpu_ack) state_next = FP_WAIT;
            end
            FP_WAIT: begin
                fpu_res_ready = !out_valid_q || bus.out_ready;
                if (bus.fpu_done && fpu_res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fp_stall_cnt <= '0;
            abort_q      <= 1'b0;
        end else begin
            if (state != IDLE && fp_stall_cnt != '1) fp_stall_cnt <= fp_stall_cnt + 32'd1;
            // Abort only once the FPU has taken the op (ack seen now or earlier).
            abort_q <= flush && ((state == FP_ISSUE && bus.fpu_ack) || state == FP_WAIT);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_store_q  <= '0;
            out_rdist_q  <= '0;
            out_rw_q     <= 1'b0;
            out_fp_q     <= 1'b0;
            out_pc_q     <= '0;
            out_bt_q     <= '0;
            out_tag_q    <= '0;
            fp_op_q      <= '0;
            fp_a_q       <= '0;
            fp_b_q       <= '0;
            h_store_q    <= '0;
            h_rdist_q    <= '0;
            h_rw_q       <= 1'b0;
            h_pc_q       <= '0;
            h_bt_q       <= '0;
            h_tag_q      <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept && !fp_path) begin
            out_valid_q  <= 1'b1;
            out_result_q <= alu_res;
            out_store_q  <= bus.in_op2;
            out_rdist_q  <= rdist;
            out_rw_q     <= bus.in_reg_write;
            out_fp_q     <= 1'b0;
            out_pc_q     <= bus.in_pc;
            out_bt_q     <= btarget;
            out_tag_q    <= bus.in_tag;
        end else if (accept) begin
            // in_ready implies the current output drains on this edge.
            out_valid_q <= 1'b0;
            fp_op_q     <= bus.in_alu_op;
            fp_a_q      <= bus.in_op1;
            fp_b_q      <= op2_sel;
            h_store_q   <= bus.in_op2;
            h_rdist_q   <= rdist;
            h_rw_q      <= bus.in_reg_write;
            h_pc_q      <= bus.in_pc;
            h_bt_q      <= btarget;
            h_tag_q     <= bus.in_tag;
        end else if (fp_take) begin
            out_valid_q  <= 1'b1;
            out_result_q <= bus.fpu_result;
            out_store_q  <= h_store_q;
            out_rdist_q  <= h_rdist_q;
            out_rw_q     <= h_rw_q;
            out_fp_q     <= 1'b1;
            out_pc_q     <= h_pc_q;
            out_bt_q     <= h_bt_q;
            out_tag_q    <= h_tag_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.fpu_req           = fpu_req;
    assign bus.fpu_res_ready     = fpu_res_ready;
    assign bus.fpu_op            = fp_op_q;
    assign bus.fpu_a             = fp_a_q;
    assign bus.fpu_b             = fp_b_q;
    assign bus.fpu_abort         = abort_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_result        = out_result_q;
    assign bus.out_store_data    = out_store_q;
    assign bus.out_rdist         = out_rdist_q;
    assign bus.out_reg_write     = out_rw_q;
    assign bus.out_fp            = out_fp_q;
    assign bus.out_pc            = out_pc_q;
    assign bus.out_branch_target = out_bt_q;
    assign bus.out_tag           = out_tag_q;
endmodule

// File: tb/tb_exec_stage_hs.sv
// Directed bench for exec_stage_hs: a transaction-level model feeds an in-order scoreboard,
// and hand-computed literals pin the key cases.
module tb_exec_stage_hs;
    localparam int DW = 32;
    localparam int IW = 14;
    localparam int TW = 8;

    typedef struct packed {
        logic        is_fp;
        logic        is_mem;
        logic [3:0]  op;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic        rw;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] imm;
        logic [13:0] pc;
        logic [7:0]  tag;
    } stim_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  rdist;
        logic        rw;
        logic        fp;
        logic [13:0] pc;
        logic [13:0] bt;
        logic [7:0]  tag;
    } txn_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] fp_stall_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    txn_t        expq[$];

    exec_stage_hs_if #(.DATA_W(DW), .INST_MEM_WIDTH(IW), .TAG_W(TW)) bus ();

    exec_stage_hs #(.DATA_W(DW), .INST_MEM_WIDTH(IW), .TAG_W(TW)) dut (
        .CLK(CLK), .reset(reset), .flush(flush), .bus(bus), .fp_stall_cnt(fp_stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_op2(input stim_t s);
        case (s.src)
            2'd0:    return s.op2;
            2'd1:    return 32'(s.sa);
            2'd2:    return {{16{s.imm[15]}}, s.imm};
            default: return 32'(s.imm);
        endcase
    endfunction

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = 32'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return a << sh;
            4'd7:  return a >> sh;
            4'd8:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10: return (a < b) ? 32'd1 : 32'd0;
            4'd11: return b << 16;
            default: return 32'd0;
        endcase
    endfunction

    function automatic txn_t model(input stim_t s, input logic fp, input logic [31:0] fpres);
        txn_t t;
        t.result = fp ? fpres : model_alu(s.op, s.op1, model_op2(s));
        t.store  = s.op2;
        t.rdist  = (s.dst == 2'd0) ? s.rd : (s.dst == 2'd1) ? s.rt : (s.dst == 2'd2) ? 5'd31 : 5'd0;
        t.rw     = s.rw;
        t.fp     = fp;
        t.pc     = s.pc;
        t.bt     = 14'((int'(s.pc) + 1 + int'(s.imm)) % 16384);
        t.tag    = s.tag;
        return t;
    endfunction

    function automatic stim_t mk(input logic [3:0] op, input logic [1:0] src, input logic [1:0] dst,
                                 input logic [31:0] op1, input logic [31:0] op2, input logic [15:0] imm,
                                 input logic [13:0] pc, input logic [7:0] tag);
        stim_t s;
        s = '0;
        s.op = op; s.src = src; s.dst = dst; s.op1 = op1; s.op2 = op2;
        s.imm = imm; s.pc = pc; s.tag = tag;
        s.rt = 5'd9; s.rd = 5'd3; s.sa = 5'd4; s.rw = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.in_is_fp     = s.is_fp;
        bus.in_is_mem    = s.is_mem;
        bus.in_alu_op    = s.op;
        bus.in_src_sel   = s.src;
        bus.in_dst_sel   = s.dst;
        bus.in_reg_write = s.rw;
        bus.in_op1       = s.op1;
        bus.in_op2       = s.op2;
        bus.in_rt        = s.rt;
        bus.in_rd        = s.rd;
        bus.in_sa        = s.sa;
        bus.in_imm       = s.imm;
        bus.in_pc        = s.pc;
        bus.in_tag       = s.tag;
    endtask

    // Present s until accepted; leaves in_valid high on return (one edge after acceptance).
    task automatic send(input stim_t s);
        bit ok;
        ok = 1'b0;
        drive(s);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                ok = 1'b1;
                if (!(s.is_fp && !s.is_mem)) expq.push_back(model(s, 1'b0, 32'd0));
                break;
            end
            @(posedge CLK); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance within 40 cycles");
        end
        @(posedge CLK); #1;
    endtask

    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    // Scoreboard and output-hold checker
    txn_t held;
    bit   held_v = 1'b0;
    always @(negedge CLK) begin
        txn_t cur, e;
        cur = {bus.out_result, bus.out_store_data, bus.out_rdist, bus.out_reg_write, bus.out_fp,
               bus.out_pc, bus.out_branch_target, bus.out_tag};
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_fields", 128'(cur), 128'(held));
                chk("hold_valid", 128'(bus.out_valid), 128'(1));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_output: got %0h expected no transaction", cur);
                end else begin
                    e = expq.pop_front();
                    chk("out_txn", 128'(cur), 128'(e));
                end
            end
            held_v = bus.out_valid && !bus.out_ready && !flush;
            held   = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        stim_t s, b;
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; drive('0);
        bus.out_ready = 1'b1; bus.fpu_ack = 1'b0; bus.fpu_done = 1'b0; bus.fpu_result = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_result", 128'(bus.out_result), 128'(0));
        chk("rst_stall_cnt", 128'(fp_stall_cnt), 128'(0));
        chk("rst_fpu_req", 128'(bus.fpu_req), 128'(0));
        chk("rst_fpu_abort", 128'(bus.fpu_abort), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        cyc(); reset = 1'b0;
        @(negedge CLK); chk("idle_in_ready", 128'(bus.in_ready), 128'(1));
        cyc();

        // add 5+7 -> 12, rd
        send(mk(4'd0, 2'd0, 2'd0, 32'd5, 32'd7, 16'd0, 14'd4, 8'hA5));
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("add_valid", 128'(bus.out_valid), 128'(1));
        chk("add_result", 128'(bus.out_result), 128'(12));
        chk("add_rdist", 128'(bus.out_rdist), 128'(3));
        cyc();

        // sign-extended immediates and branch-target wrap
        send(mk(4'd0, 2'd2, 2'd1, 32'd1, 32'hDEAD, 16'hFFFF, 14'd10, 8'h11));
        bus.in_valid = 1'b0;
        @(negedge CLK); chk("sext_result", 128'(bus.out_result), 128'(0));
        cyc();
        send(mk(4'd0, 2'd2, 2'd2, 32'd1, 32'd0, 16'hFFFE, 14'd10, 8'h12));
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("bt_wrap", 128'(bus.out_branch_target), 128'(9));
        chk("sext_neg_result", 128'(bus.out_result), 128'(32'hFFFF_FFFF));
        chk("rdist_31", 128'(bus.out_rdist), 128'(31));
        cyc();

        // all opcodes, back to back, two operand patterns
        for (int op = 0; op < 16; op++)
            send(mk(4'(op), 2'd0, 2'(op % 4), 32'h8000_00F3, 32'h0000_0024, 16'h8001, 14'(op * 100), 8'(op)));
        for (int op = 0; op < 16; op++)
            send(mk(4'(op), 2'(op % 4), 2'(3 - op % 4), 32'h7FFF_FFF0, 32'hFFFF_0003, 16'hF00D, 14'(16383 - op), 8'(op + 64)));
        bus.in_valid = 1'b0;
        cyc(); cyc();

        // backpressure: hold A for 3 cycles, then B follows with no bubble
        bus.out_ready = 1'b0;
        send(mk(4'd1, 2'd0, 2'd0, 32'd100, 32'd30, 16'd0, 14'd50, 8'h0A));
        b = mk(4'd4, 2'd3, 2'd0, 32'hFF00_FF00, 32'd0, 16'h0FF0, 14'd51, 8'h0B);
        drive(b);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
            chk("bp_hold_result", 128'(bus.out_result), 128'(70));
            cyc();
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_in_ready_release", 128'(bus.in_ready), 128'(1));
        expq.push_back(model(b, 1'b0, 32'd0));
        cyc(); bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("bp_no_bubble", 128'(bus.out_valid), 128'(1));
        chk("bp_next_result", 128'(bus.out_result), 128'(32'hFF00_F0F0));
        cyc();

        // FP op: ack on 2nd issue cycle, done 4 cycles later
        s = mk(4'd3, 2'd0, 2'd1, 32'h4000_0000, 32'h3F00_0000, 16'd0, 14'd200, 8'h5A);
        s.is_fp = 1'b1;
        send(s);
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("fp_req", 128'(bus.fpu_req), 128'(1));
        chk("fp_op", 128'(bus.fpu_op), 128'(3));
        chk("fp_a", 128'(bus.fpu_a), 128'(32'h4000_0000));
        chk("fp_b", 128'(bus.fpu_b), 128'(32'h3F00_0000));
        chk("fp_in_ready", 128'(bus.in_ready), 128'(0));
        cyc(); bus.fpu_ack = 1'b1;
        @(negedge CLK);
        chk("fp_req_held", 128'(bus.fpu_req), 128'(1));
        chk("fp_in_ready", 128'(bus.in_ready), 128'(0));
        cyc(); bus.fpu_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("fp_req_low", 128'(bus.fpu_req), 128'(0));
            chk("fp_wait_in_ready", 128'(bus.in_ready), 128'(0));
            chk("fp_res_ready", 128'(bus.fpu_res_ready), 128'(1));
            cyc();
        end
        bus.fpu_done = 1'b1; bus.fpu_result = 32'h3F80_0000;
        @(negedge CLK);
        chk("fp_res_ready_done", 128'(bus.fpu_res_ready), 128'(1));
        expq.push_back(model(s, 1'b1, 32'h3F80_0000));
        cyc(); bus.fpu_done = 1'b0; bus.fpu_result = '0;
        @(negedge CLK);
        chk("fp_out_valid", 128'(bus.out_valid), 128'(1));
        chk("fp_out_fp", 128'(bus.out_fp), 128'(1));
        chk("fp_out_result", 128'(bus.out_result), 128'(32'h3F80_0000));
        chk("fp_stall_cnt", 128'(fp_stall_cnt), 128'(6));
        chk("fp_back_idle", 128'(bus.in_ready), 128'(1));
        cyc();

        // FP-flagged memory op stays on the integer path
        s = mk(4'd0, 2'd2, 2'd0, 32'h1000, 32'h55, 16'h0010, 14'd300, 8'h33);
        s.is_fp = 1'b1; s.is_mem = 1'b1;
        send(s);
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("mem_fpu_req", 128'(bus.fpu_req), 128'(0));
        chk("mem_valid", 128'(bus.out_valid), 128'(1));
        chk("mem_result", 128'(bus.out_result), 128'(32'h1010));
        chk("mem_out_fp", 128'(bus.out_fp), 128'(0));
        cyc();
        @(negedge CLK);
        chk("mem_fpu_req2", 128'(bus.fpu_req), 128'(0));
        chk("mem_stall_cnt", 128'(fp_stall_cnt), 128'(6));
        cyc();

        // flush in FP_WAIT coincident with fpu_done, with a competing in_valid
        s = mk(4'd2, 2'd0, 2'd0, 32'h1, 32'h2, 16'd0, 14'd400, 8'h44);
        s.is_fp = 1'b1;
        send(s);
        bus.in_valid = 1'b0; bus.fpu_ack = 1'b1;
        @(negedge CLK); chk("fl_req", 128'(bus.fpu_req), 128'(1));
        cyc();
        bus.fpu_ack = 1'b0; bus.fpu_done = 1'b1; bus.fpu_result = 32'hDEAD_BEEF; flush = 1'b1;
        drive(mk(4'd0, 2'd0, 2'd0, 32'd1, 32'd1, 16'd0, 14'd401, 8'h45));
        bus.in_valid = 1'b1;
        @(negedge CLK);
        chk("fl_in_ready", 128'(bus.in_ready), 128'(0));
        chk("fl_abort_early", 128'(bus.fpu_abort), 128'(0));
        cyc();
        flush = 1'b0; bus.fpu_done = 1'b0; bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("fl_abort", 128'(bus.fpu_abort), 128'(1));
        chk("fl_out_valid", 128'(bus.out_valid), 128'(0));
        chk("fl_in_ready_after", 128'(bus.in_ready), 128'(1));
        chk("fl_fpu_req", 128'(bus.fpu_req), 128'(0));
        cyc();
        @(negedge CLK);
        chk("fl_abort_end", 128'(bus.fpu_abort), 128'(0));
        chk("fl_out_valid2", 128'(bus.out_valid), 128'(0));
        chk("fl_stall_cnt", 128'(fp_stall_cnt), 128'(8));
        cyc();

        // flush in FP_ISSUE before ack: nothing outstanding, no abort
        s.pc = 14'd500;
        send(s);
        bus.in_valid = 1'b0; flush = 1'b1;
        cyc(); flush = 1'b0;
        @(negedge CLK);
        chk("iss_abort", 128'(bus.fpu_abort), 128'(0));
        chk("iss_req", 128'(bus.fpu_req), 128'(0));
        chk("iss_in_ready", 128'(bus.in_ready), 128'(1));
        chk("iss_stall_cnt", 128'(fp_stall_cnt), 128'(9));
        cyc();

        // flush while the output handshakes: the result still counts as delivered
        send(mk(4'd5, 2'd0, 2'd1, 32'h0F0F_0000, 32'h0000_00F0, 16'd0, 14'd600, 8'h66));
        bus.in_valid = 1'b0; flush = 1'b1;
        @(negedge CLK); chk("fd_valid_before", 128'(bus.out_valid), 128'(1));
        cyc(); flush = 1'b0;
        @(negedge CLK); chk("fd_valid_after", 128'(bus.out_valid), 128'(0));
        cyc(); cyc();

        chk("queue_empty", 128'(expq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
